// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encoding, RV32I opcodes, decoded issue entry and decode function
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    alu_op_e     op;
    logic        qual;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_entry_t;
  function automatic issue_entry_t decode(input logic [31:0] instr, pc, rs1, rs2);
    issue_entry_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = instr[31:25];
    f3 = instr[14:12];
    e = '0;
    e.rd = instr[11:7];
    e.illegal = 1'b1;
    case (instr[6:0])
      OPC_OP: begin
        e.in1 = rs1;
        e.in2 = rs2;
        e.op = alu_op_e'(f3);
        e.qual = instr[30];
        e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        e.in1 = rs1;
        e.in2 = {{20{instr[31]}}, instr[31:20]};
        e.op = alu_op_e'(f3);
        e.qual = f3 == 3'b101 && instr[30];
        e.illegal = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_LUI: begin
        e.in2 = {instr[31:12], 12'b0};
        e.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        e.in1 = pc;
        e.in2 = {instr[31:12], 12'b0};
        e.illegal = 1'b0;
      end
      default: ;
    endcase
    if (e.illegal) begin
      e.in1 = '0;
      e.in2 = '0;
      e.op = ALU_ADD;
      e.qual = 1'b0;
    end
    e.rd_we = !e.illegal && e.rd != 5'd0;
    return e;
  endfunction
endpackage

// File: rtl/rv_skid_buffer.sv
// rv_skid_buffer: 2-entry valid/ready buffer, main entry drives output, skid catches overflow
module rv_skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset_i,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);
  logic main_v, skid_v;
  T main_q, skid_q;
  logic in_fire, out_fire;
  assign in_fire = in_valid_i && !skid_v;
  assign out_fire = main_v && out_ready_i;
  assign in_ready_o = !skid_v;
  assign out_valid_o = main_v;
  assign out_data_o = main_q;
  always_ff @(posedge clk) begin
    if (reset_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (out_fire) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_v || out_fire) begin
        main_q <= in_data_i;
        main_v <= 1'b1;
      end else begin
        skid_q <= in_data_i;
        skid_v <= 1'b1;
      end
    end else if (out_fire) begin
      main_v <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I ALU decode/issue stage with registered skid-buffered output and issue counter
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      rs2_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      alu_in1_o,
  output logic [31:0]      alu_in2_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_qual_o,
  output logic [4:0]       rd_o,
  output logic             rd_we_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] issue_cnt_o
);
  issue_entry_t in_e, out_e;
  assign in_e = decode(instr_i, pc_i, rs1_data_i, rs2_data_i);
  rv_skid_buffer #(.T(issue_entry_t)) u_skid (
    .clk        (clk),
    .reset_i    (reset_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_e),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_e)
  );
  assign alu_in1_o = out_e.in1;
  assign alu_in2_o = out_e.in2;
  assign alu_op_o = out_e.op;
  assign alu_qual_o = out_e.qual;
  assign rd_o = out_e.rd;
  assign rd_we_o = out_e.rd_we;
  assign illegal_o = out_e.illegal;
  // a transfer taken in a flush cycle still counts
  always_ff @(posedge clk) begin
    if (reset_i) issue_cnt_o <= '0;
    else if (out_valid_o && out_ready_i) issue_cnt_o <= issue_cnt_o + CNT_W'(1);
  end
endmodule
